uart_rx_unit: RTL and testbench
===============================

# uart_rx_unit

Oversampling UART receiver that pairs with the baud-rate tick generator: it consumes the one-clock enable pulse emitted at OVS× the bit rate and turns a serial rxd line into parallel bytes. It sits between the pad synchronizer-free rxd input and the host/Wishbone register layer, exposing a ready/read handshake with sticky error flags.

## Interface
- OVS, 16: oversampling ratio; ticks per bit; even, ≥ 4.
- DATA_BITS, 8: data bits per frame, 5..8, LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.

- clk_i  in  1  system clock; all logic on rising edge.
- reset_n_i  in  1  reset, asynchronous, active-low.
- ce_i  in  1  oversample tick, one clk_i wide, OVS per bit period.
- rxd_i  in  1  raw serial line, idle high, asynchronous to clk_i.
- rd_i  in  1  host read strobe; consumes current byte and clears flags.
- data_o  out  DATA_BITS  last received byte.
- ready_o  out  1  byte available (level).
- ferr_o  out  1  framing error (stop bit sampled 0), sticky.
- perr_o  out  1  parity error, sticky; always 0 when PARITY=0.
- oerr_o  out  1  overrun, sticky.
- busy_o  out  1  frame in progress (state ≠ IDLE).

## Operation
- rxd_i passes a 2-FF synchronizer (reset value 1); all decisions use synchronized value rxs. Synchronizer runs every clk_i; everything else advances only on clk_i edges with ce_i=1.
- Tick counter cnt, width $clog2(OVS), 0..OVS-1, wraps to 0. Bit counter nbit, 0..DATA_BITS-1.
- Bit value = majority of rxs at cnt = OVS/2-1, OVS/2, OVS/2+1; decision taken at cnt = OVS/2+1.
- States:
  - IDLE: on tick with rxs=0 → START, cnt←1.
  - START: at decision, majority 1 → IDLE (glitch rejected, no flags); else continue; at cnt wrap → DATA, nbit←0.
  - DATA: at decision shift bit into shift register MSB side (LSB first on line); at wrap nbit++; after bit DATA_BITS-1 → PARITY if PARITY≠0 else STOP.
  - PARITY: at decision compare with XOR of data (odd: XOR^1 expected); at wrap → STOP.
  - STOP: at decision complete frame (see below); majority 1 → IDLE, majority 0 → BREAK. No wait for full stop bit, allowing resync on next start edge.
  - BREAK: stay until tick with rxs=1 → IDLE.
- Frame completion (one clk_i): data_o ← shift register; ready_o←1; ferr_o|=(stop=0); perr_o|=parity mismatch; oerr_o|=(ready_o=1 and rd_i=0). New byte always overwrites data_o.
- rd_i=1 clears ready_o, ferr_o, perr_o, oerr_o, unless a completion occurs in the same cycle: then completion wins, ready_o stays 1, flags take new frame's values only (old sticky flags cleared), oerr_o not set.
- rd_i while ready_o=0: clears flags, no other effect.

## Timing
- Reset (async assert, sync release by surrounding logic): state IDLE, cnt=0, nbit=0, data_o=0, ready_o=0, ferr_o=perr_o=oerr_o=0, busy_o=0, synchronizer=1.
- Reset mid-frame: frame discarded, no flags, outputs return to reset values immediately.
- Start detection latency: 2 clk synchronizer + up to one tick period.
- ready_o rises on clk_i edge following the ce_i tick at stop-bit cnt=OVS/2+1; i.e. ≈ (1+DATA_BITS+P+0.5)·OVS ticks after start edge, P=1 if parity.
- busy_o rises with IDLE→START, falls on STOP→IDLE or BREAK→IDLE.
- ce_i held 0: state frozen; ce_i continuously 1 is legal (clk = OVS×baud).

## Test plan
- OVS=16, 8N1, ce_i every clk: send 0xA5 → data_o=0xA5, ready_o=1, all error flags 0, ready_o rises 8+16·9 = 152 ±2 clk after falling edge; rd_i pulse → ready_o=0.
- Low glitch of 4 ticks on idle line → returns to IDLE from START, busy_o pulses, ready_o stays 0.
- 0x3C with stop bit forced 0, line held low 40 ticks then high → data_o=0x3C, ferr_o=1, state BREAK until line high, then accepts next 0x81 cleanly (ferr_o remains until rd_i).
- PARITY=2: send 0x07 with parity 1 → perr_o=0; with parity 0 → perr_o=1.
- Two bytes 0x11, 0x22 without rd_i → data_o=0x22, oerr_o=1; repeat with rd_i in exact completion cycle → ready_o=1, oerr_o=0.
- Assert reset_n_i=0 mid data bit 4, release, send 0x5A → no spurious ready, then data_o=0x5A.

Source files
------------

// File: rtl/uart_rx_unit.sv
// Oversampling UART receiver: 2-FF synchronized rxd, majority-of-three bit decision
// on the ce_i tick grid, ready/read handshake with sticky framing/parity/overrun flags.
module uart_rx_unit #(
    parameter int OVS       = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 ce_i,
    input  logic                 rxd_i,
    input  logic                 rd_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 ready_o,
    output logic                 ferr_o,
    output logic                 perr_o,
    output logic                 oerr_o,
    output logic                 busy_o
);

    localparam int CW = $clog2(OVS);
    localparam int NW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] C_S0   = CW'(OVS/2 - 1);
    localparam logic [CW-1:0] C_S1   = CW'(OVS/2);
    localparam logic [CW-1:0] C_DEC  = CW'(OVS/2 + 1);
    localparam logic [CW-1:0] C_WRAP = CW'(OVS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state_reg;
    logic                   rxd_meta_reg;
    logic                   rxs_reg;
    logic [CW-1:0]          cnt_reg;
    logic [NW-1:0]          nbit_reg;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   smp0_reg;
    logic                   smp1_reg;
    logic                   perr_frame_reg;

    logic                   majority;
    logic                   at_dec;
    logic                   at_wrap;
    logic [CW-1:0]          cnt_next;
    logic                   par_exp;
    logic                   complete;

    assign majority = (smp0_reg & smp1_reg) | (smp0_reg & rxs_reg) | (smp1_reg & rxs_reg);
    assign at_dec   = (cnt_reg == C_DEC);
    assign at_wrap  = (cnt_reg == C_WRAP);
    assign cnt_next = at_wrap ? '0 : cnt_reg + CW'(1);
    // Odd parity expects the complement of the data XOR
    assign par_exp  = (^shift_reg) ^ (PARITY == 1);
    assign complete = ce_i && (state_reg == S_STOP) && at_dec;
    assign busy_o   = (state_reg != S_IDLE);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rxd_meta_reg <= 1'b1;
            rxs_reg      <= 1'b1;
        end else begin
            rxd_meta_reg <= rxd_i;
            rxs_reg      <= rxd_meta_reg;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            nbit_reg       <= '0;
            shift_reg      <= '0;
            smp0_reg       <= 1'b1;
            smp1_reg       <= 1'b1;
            perr_frame_reg <= 1'b0;
            data_o         <= '0;
            ready_o        <= 1'b0;
            ferr_o         <= 1'b0;
            perr_o         <= 1'b0;
            oerr_o         <= 1'b0;
        end else begin
            if (ce_i) begin
                if (cnt_reg == C_S0) smp0_reg <= rxs_reg;
                if (cnt_reg == C_S1) smp1_reg <= rxs_reg;
                case (state_reg)
                    S_IDLE: begin
                        if (!rxs_reg) begin
                            state_reg      <= S_START;
                            cnt_reg        <= CW'(1);
                            perr_frame_reg <= 1'b0;
                        end
                    end
                    S_START: begin
                        cnt_reg <= cnt_next;
                        if (at_dec && majority) begin
                            state_reg <= S_IDLE;
                            cnt_reg   <= '0;
                        end else if (at_wrap) begin
                            state_reg <= S_DATA;
                            nbit_reg  <= '0;
                        end
                    end
                    S_DATA: begin
                        cnt_reg <= cnt_next;
                        if (at_dec) shift_reg <= {majority, shift_reg[DATA_BITS-1:1]};
                        if (at_wrap) begin
                            if (nbit_reg == N_LAST)
                                state_reg <= (PARITY != 0) ? S_PARITY : S_STOP;
                            else
                                nbit_reg <= nbit_reg + NW'(1);
                        end
                    end
                    S_PARITY: begin
                        cnt_reg <= cnt_next;
                        if (at_dec) perr_frame_reg <= majority ^ par_exp;
                        if (at_wrap) state_reg <= S_STOP;
                    end
                    S_STOP: begin
                        cnt_reg <= cnt_next;
                        // Decide at mid-stop so the next start edge can be caught early
                        if (at_dec) begin
                            cnt_reg   <= '0;
                            state_reg <= majority ? S_IDLE : S_BREAK;
                        end
                    end
                    S_BREAK: begin
                        if (rxs_reg) state_reg <= S_IDLE;
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end

            // A completion coinciding with rd_i replaces the old flags outright
            if (complete) begin
                data_o  <= shift_reg;
                ready_o <= 1'b1;
                if (rd_i) begin
                    ferr_o <= ~majority;
                    perr_o <= perr_frame_reg;
                    oerr_o <= 1'b0;
                end else begin
                    ferr_o <= ferr_o | ~majority;
                    perr_o <= perr_o | perr_frame_reg;
                    oerr_o <= oerr_o | ready_o;
                end
            end else if (rd_i) begin
                ready_o <= 1'b0;
                ferr_o  <= 1'b0;
                perr_o  <= 1'b0;
                oerr_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed bench for uart_rx_unit: 8N1 instance and an even-parity instance,
// ce_i every clock (16 clocks per bit), one task per scenario.
module tb_uart_rx_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       ce;
    logic       rxd0, rd0, rxd1, rd1;
    logic [7:0] data0, data1;
    logic       ready0, ferr0, perr0, oerr0, busy0;
    logic       ready1, ferr1, perr1, oerr1, busy1;

    uart_rx_unit #(.OVS(16), .DATA_BITS(8), .PARITY(0)) dut0 (
        .clk_i(clk), .reset_n_i(reset_n), .ce_i(ce), .rxd_i(rxd0), .rd_i(rd0),
        .data_o(data0), .ready_o(ready0), .ferr_o(ferr0), .perr_o(perr0),
        .oerr_o(oerr0), .busy_o(busy0)
    );

    uart_rx_unit #(.OVS(16), .DATA_BITS(8), .PARITY(2)) dut1 (
        .clk_i(clk), .reset_n_i(reset_n), .ce_i(ce), .rxd_i(rxd1), .rd_i(rd1),
        .data_o(data1), .ready_o(ready1), .ferr_o(ferr1), .perr_o(perr1),
        .oerr_o(oerr1), .busy_o(busy1)
    );

    int   checks = 0;
    int   fails  = 0;
    int   cyc = 0;
    int   busy_rise_cyc = 0;
    int   ready_rise_cyc = 0;
    int   busy_rises = 0;
    logic busy_prev = 1'b0;
    logic ready_prev = 1'b0;

    // Edge monitor for instance 0, sampled 1ns after each rising edge
    always @(posedge clk) begin
        cyc++;
        #1;
        if (busy0 && !busy_prev) begin
            busy_rise_cyc = cyc;
            busy_rises++;
        end
        if (ready0 && !ready_prev) ready_rise_cyc = cyc;
        busy_prev  = busy0;
        ready_prev = ready0;
    end

    function automatic logic [15:0] mk(input logic [7:0] d, input bit pe, input bit pb, input bit sb);
        logic [15:0] b;
        b      = '1;
        b[0]   = 1'b0;
        b[8:1] = d;
        if (pe) begin
            b[9]  = pb;
            b[10] = sb;
        end else begin
            b[9] = sb;
        end
        return b;
    endfunction

    // Line bit k occupies drive edges 16k+1 .. 16k+16; rd pulses on edge rd_edge
    task automatic drive(input bit inst, input logic [15:0] bits, input int n_edges,
                         input int rd_edge, output int start_cyc);
        start_cyc = 0;
        for (int e = 1; e <= n_edges; e++) begin
            @(negedge clk);
            if (e == 1) start_cyc = cyc;
            if (inst) rxd1 = bits[(e-1)/16];
            else      rxd0 = bits[(e-1)/16];
            rd0 = !inst && (e == rd_edge);
            rd1 = inst && (e == rd_edge);
        end
        @(posedge clk);
        #1;
        rd0 = 1'b0;
        rd1 = 1'b0;
        $display("frame inst=%0d bits=%04h edges=%0d rd_edge=%0d -> data0=%02h rdy0=%b data1=%02h rdy1=%b",
                 inst, bits, n_edges, rd_edge, data0, ready0, data1, ready1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rxd0 = 1'b1; rxd1 = 1'b1; rd0 = 1'b0; rd1 = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd_pulse(input bit inst);
        @(negedge clk);
        if (inst) rd1 = 1'b1; else rd0 = 1'b1;
        @(posedge clk);
        #1;
        rd0 = 1'b0;
        rd1 = 1'b0;
        $display("read inst=%0d -> rdy0=%b rdy1=%b", inst, ready0, ready1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ce = 1'b1; rxd0 = 1'b1; rxd1 = 1'b1; rd0 = 1'b0; rd1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({data0, ready0, ferr0, perr0, oerr0, busy0} !== 13'h0) begin
            fails++;
            $display("FAIL reset_hold0: got %h want 0", {data0, ready0, ferr0, perr0, oerr0, busy0});
        end
        checks++;
        if ({data1, ready1, ferr1, perr1, oerr1, busy1} !== 13'h0) begin
            fails++;
            $display("FAIL reset_hold1: got %h want 0", {data1, ready1, ferr1, perr1, oerr1, busy1});
        end
        reset_n = 1'b1;
        idle(10);
        checks++;
        if ({ready0, busy0, ready1, busy1} !== 4'h0) begin
            fails++;
            $display("FAIL reset_release: got %b want 0000", {ready0, busy0, ready1, busy1});
        end
    endtask

    task automatic test_basic();
        int sc;
        drive(1'b0, mk(8'hA5, 0, 0, 1), 160, 0, sc);
        checks++;
        if (data0 !== 8'hA5) begin fails++; $display("FAIL basic_data: got %h want a5", data0); end
        checks++;
        if ({ready0, ferr0, perr0, oerr0} !== 4'b1000) begin
            fails++; $display("FAIL basic_flags: got %b want 1000", {ready0, ferr0, perr0, oerr0});
        end
        // Nominal 152 clk from line edge, plus synchronizer and detection-tick latency
        checks++;
        if ((ready_rise_cyc - sc) < 150 || (ready_rise_cyc - sc) > 158) begin
            fails++; $display("FAIL basic_latency: got %0d want 150..158", ready_rise_cyc - sc);
        end
        // Start entry is tick 0 with cnt=1; stop decision is tick 9*16+9
        checks++;
        if ((ready_rise_cyc - busy_rise_cyc) !== 153) begin
            fails++; $display("FAIL basic_busy_to_ready: got %0d want 153", ready_rise_cyc - busy_rise_cyc);
        end
        rd_pulse(1'b0);
        checks++;
        if (ready0 !== 1'b0) begin fails++; $display("FAIL basic_read_clear: got %b want 0", ready0); end
    endtask

    task automatic test_glitch();
        int n0;
        idle(5);
        n0 = busy_rises;
        repeat (4) begin @(negedge clk); rxd0 = 1'b0; end
        idle(30);
        $display("glitch inst=0 -> busy=%b rdy=%b", busy0, ready0);
        checks++;
        if (busy_rises !== n0 + 1) begin fails++; $display("FAIL glitch_busy_pulse: got %0d want %0d", busy_rises, n0 + 1); end
        checks++;
        if ({busy0, ready0, ferr0} !== 3'b000) begin
            fails++; $display("FAIL glitch_idle: got %b want 000", {busy0, ready0, ferr0});
        end
    endtask

    task automatic test_break();
        int          sc;
        logic [15:0] b;
        b     = mk(8'h3C, 0, 0, 0);
        b[10] = 1'b0;
        b[11] = 1'b0;
        drive(1'b0, b, 184, 0, sc);
        checks++;
        if ({data0, ready0, ferr0, busy0} !== {8'h3C, 3'b111}) begin
            fails++; $display("FAIL break_frame: got %h/%b want 3c/111", data0, {ready0, ferr0, busy0});
        end
        idle(20);
        checks++;
        if (busy0 !== 1'b0) begin fails++; $display("FAIL break_exit: got busy %b want 0", busy0); end
        drive(1'b0, mk(8'h81, 0, 0, 1), 160, 0, sc);
        checks++;
        if ({data0, ready0, ferr0, oerr0} !== {8'h81, 3'b111}) begin
            fails++; $display("FAIL break_next: got %h/%b want 81/111", data0, {ready0, ferr0, oerr0});
        end
        rd_pulse(1'b0);
        checks++;
        if ({ready0, ferr0, oerr0} !== 3'b000) begin
            fails++; $display("FAIL break_read_clear: got %b want 000", {ready0, ferr0, oerr0});
        end
    endtask

    task automatic test_back_to_back();
        int sc;
        drive(1'b0, mk(8'h11, 0, 0, 1), 160, 0, sc);
        drive(1'b0, mk(8'h22, 0, 0, 1), 160, 0, sc);
        checks++;
        if ({data0, ready0, oerr0} !== {8'h22, 2'b11}) begin
            fails++; $display("FAIL overrun: got %h/%b want 22/11", data0, {ready0, oerr0});
        end
        rd_pulse(1'b0);
        drive(1'b0, mk(8'h11, 0, 0, 1), 160, 0, sc);
        drive(1'b0, mk(8'h22, 0, 0, 1), 160, 156, sc);
        checks++;
        if ({data0, ready0, oerr0, ferr0} !== {8'h22, 3'b100}) begin
            fails++; $display("FAIL read_at_completion: got %h/%b want 22/100", data0, {ready0, oerr0, ferr0});
        end
        rd_pulse(1'b0);
    endtask

    task automatic test_parity();
        int sc;
        drive(1'b1, mk(8'h07, 1, 1, 1), 176, 0, sc);
        checks++;
        if ({data1, ready1, perr1, ferr1} !== {8'h07, 3'b100}) begin
            fails++; $display("FAIL parity_good: got %h/%b want 07/100", data1, {ready1, perr1, ferr1});
        end
        rd_pulse(1'b1);
        drive(1'b1, mk(8'h07, 1, 0, 1), 176, 0, sc);
        checks++;
        if ({data1, ready1, perr1, ferr1} !== {8'h07, 3'b110}) begin
            fails++; $display("FAIL parity_bad: got %h/%b want 07/110", data1, {ready1, perr1, ferr1});
        end
        rd_pulse(1'b1);
        checks++;
        if ({ready1, perr1} !== 2'b00) begin fails++; $display("FAIL parity_clear: got %b want 00", {ready1, perr1}); end
    endtask

    task automatic test_reset_mid_frame();
        int sc;
        drive(1'b0, mk(8'h00, 0, 0, 1), 88, 0, sc);
        checks++;
        if (busy0 !== 1'b1) begin fails++; $display("FAIL midframe_busy: got %b want 1", busy0); end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({data0, ready0, busy0} !== 10'h0) begin
            fails++; $display("FAIL midframe_async_reset: got %h/%b want 00/00", data0, {ready0, busy0});
        end
        rxd0 = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        idle(40);
        checks++;
        if ({ready0, busy0, ferr0} !== 3'b000) begin
            fails++; $display("FAIL midframe_no_spurious: got %b want 000", {ready0, busy0, ferr0});
        end
        drive(1'b0, mk(8'h5A, 0, 0, 1), 160, 0, sc);
        checks++;
        if ({data0, ready0, ferr0, perr0, oerr0} !== {8'h5A, 4'b1000}) begin
            fails++; $display("FAIL midframe_next: got %h/%b want 5a/1000", data0, {ready0, ferr0, perr0, oerr0});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_back_to_back();
        test_parity();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
